uart_cfg_core: RTL and testbench
================================

Name: uart_cfg_core

Overview:
Parametrised full-duplex UART, the successor to the fixed 8N1 uart_top.
- Configurable data width, parity mode and stop-bit count.
- RX uses oversampling with mid-bit sampling, false-start rejection, and parity/framing error flags.
- Sits between a byte-level host interface and the serial pins; one shared baud-tick generator serves both directions.

Parameters:
- CLK_FREQ, 1600000, system clock frequency in Hz.
- BAUD, 10000, serial bit rate in bit/s.
- OVERSAMPLE, 16, RX samples per bit; must be even and ≥4.
- DATA_BITS, 8, payload bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- rx  in  1  serial input; asynchronous, idle high.
- dintx  in  DATA_BITS  transmit payload.
- newd  in  1  transmit request, level-sensitive.
- tx  out  1  serial output; idle high.
- doutrx  out  DATA_BITS  last received payload.
- donetx  out  1  one-cycle pulse at the end of a transmitted frame.
- donerx  out  1  one-cycle pulse when doutrx, perr and ferr update.
- busytx  out  1  high while a frame is in flight.
- perr  out  1  parity error of the last received frame.
- ferr  out  1  framing error of the last received frame.

Behaviour:
- Reset (rst=0 at a clk edge):
  - tx=1; all other outputs 0; both FSMs go to IDLE; tick counter clears.
  - Reset mid-frame aborts the frame: tx is high on the next cycle and no done pulse is issued.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer division, must be ≥1.
  - tick is a one-cycle pulse every DIV clocks, free-running after reset.
  - One bit period = OVERSAMPLE ticks.
- TX FSM (IDLE → START → DATA → PARITY → STOP → IDLE):
  - IDLE with newd=1: latch dintx, set busytx=1, enter START at the next tick boundary.
  - Each state drives tx for exactly one bit period:
    - START drives 0.
    - DATA drives LSB first, DATA_BITS periods.
    - PARITY drives the parity bit: odd means the total count of 1s in data plus parity is odd. This state is skipped when PARITY=0.
    - STOP drives 1 for STOP_BITS periods.
  - At the end of the last stop bit: donetx=1 for one cycle, busytx=0, return to IDLE.
  - newd held high sends back-to-back frames; the next START begins no earlier than the cycle after donetx.
  - dintx changes after the latch have no effect on the frame in flight.
- RX input conditioning: rx passes through a 2-flop synchroniser; the FSM uses only the synchronised value.
- RX FSM (IDLE → START → DATA → PARITY → STOP → IDLE):
  - IDLE: a high-to-low transition of synchronised rx enters START. A line held low (break) never retriggers; a high level must be seen first.
  - START: wait OVERSAMPLE/2 ticks, then sample. If rx=1, treat as a false start and return to IDLE with no pulse and no flag change. Otherwise continue.
  - Subsequent bits are sampled every OVERSAMPLE ticks. Data shifts in LSB first.
  - Each stop bit is checked; ferr=1 if any stop sample is 0.
  - perr=1 on parity mismatch; perr is always 0 when PARITY=0.
  - One cycle after the final stop sample: doutrx, perr and ferr update together and donerx pulses for one cycle. Payload is delivered even when errors are flagged.
  - Flags hold until the next donerx.
- TX and RX are fully independent; simultaneous activity is legal.

Optional Feature:
UART_LOOPBACK_EN
- Defined: extra input port loopback (1 bit).
  - loopback=1: RX input is internally driven by the TX serial output (pre-pin) and the external rx is ignored; tx still drives the pin.
  - loopback must only change while both FSMs are IDLE.
- Undefined: the loopback port is absent and rx is always used.

Decomposition:
- Package uart_pkg holds:
  - Parity mode constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2.
  - FSM state encodings (3-bit).
  - The function computing DIV.
- One sub-module, uart_baud_gen: tick counter with parameter DIV and output tick.
- TX and RX FSMs live in uart_cfg_core.

Test Plan:
All scenarios use defaults unless stated: DIV=10, bit period=160 clocks.
1. Reset, then newd=1 with dintx=8'hA5 → on tx, in order:
   - start bit 0;
   - data bits 1,0,1,0,0,1,0,1 (LSB first);
   - stop bit 1.
   Each bit lasts 160 clocks; donetx pulses once, 1600 clocks after the start edge; busytx is high throughout the frame.
2. PARITY=2: send 8'h07, then inject an RX frame 0x07 with parity bit 0 → TX parity bit is 1; RX donerx with doutrx=8'h07 and perr=1.
3. DATA_BITS=7, STOP_BITS=2: RX frame 7'h55 with the second stop bit driven 0 → donerx pulses, doutrx=7'h55, ferr=1.
4. Drive rx low for 5 clocks (shorter than a half bit), then high → no donerx; doutrx, perr and ferr are unchanged.
5. Assert rst=0 at the 4th data bit of a TX frame → tx=1 on the next cycle; donetx never pulses; a new frame after release transmits correctly.
6. UART_LOOPBACK_EN defined, loopback=1: send 8'h3C while external rx is held at 0 → donerx pulses with doutrx=8'h3C, perr=0, ferr=0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: parity modes, FSM state encoding and the baud divider
// helper shared by the configurable UART core.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  function automatic int baud_div(
    input int clk_freq,
    input int baud,
    input int os
  );
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_cfg_core_if.sv
// uart_cfg_core_if: host byte interface and serial pins of the UART.
// slave faces the core, master faces the host/line model.
interface uart_cfg_core_if #(
  parameter int DATA_BITS = 8
);

  logic                 rx;
  logic                 tx;
  logic [DATA_BITS-1:0] dintx;
  logic                 newd;
  logic [DATA_BITS-1:0] doutrx;
  logic                 donetx;
  logic                 donerx;
  logic                 busytx;
  logic                 perr;
  logic                 ferr;

  modport slave (
    input  rx,
    input  dintx,
    input  newd,
    output tx,
    output doutrx,
    output donetx,
    output donerx,
    output busytx,
    output perr,
    output ferr
  );

  modport master (
    output rx,
    output dintx,
    output newd,
    input  tx,
    input  doutrx,
    input  donetx,
    input  donerx,
    input  busytx,
    input  perr,
    input  ferr
  );

endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running divider, one-cycle tick every DIV clocks.
// Counter restarts on synchronous active-low reset.
module uart_baud_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_cfg_core.sv
// uart_cfg_core: configurable full-duplex UART (width/parity/stop).
// Define UART_LOOPBACK_EN to add the internal tx->rx loopback port.
module uart_cfg_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 1600000,
  parameter int BAUD       = 10000,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input logic clk,
  input logic rst,
`ifdef UART_LOOPBACK_EN
  input logic loopback,
`endif
  uart_cfg_core_if.slave bus
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_MID  = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam bit HAS_PAR = (PARITY != PAR_NONE);

  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == PAR_ODD) ? ~^d : ^d;
  endfunction

  logic tick;

  uart_baud_gen #(
    .DIV (DIV)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // ---------------- TX ----------------
  uart_state_t          tx_st, tx_st_d;
  logic [OSW-1:0]       tx_os, tx_os_d;
  logic [3:0]           tx_cnt, tx_cnt_d;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_d;
  logic                 tx_pb, tx_pb_d;
  logic                 tx_busy, tx_busy_d;
  logic                 tx_done, tx_done_d;
  logic                 tx_end;
  logic                 tx_line;

  assign tx_end = tick && (tx_os == OS_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_st   <= ST_IDLE;
      tx_os   <= '0;
      tx_cnt  <= '0;
      tx_sh   <= '0;
      tx_pb   <= 1'b0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_st   <= tx_st_d;
      tx_os   <= tx_os_d;
      tx_cnt  <= tx_cnt_d;
      tx_sh   <= tx_sh_d;
      tx_pb   <= tx_pb_d;
      tx_busy <= tx_busy_d;
      tx_done <= tx_done_d;
    end
  end

  always_comb begin
    tx_st_d   = tx_st;
    tx_os_d   = tx_os;
    tx_cnt_d  = tx_cnt;
    tx_sh_d   = tx_sh;
    tx_pb_d   = tx_pb;
    tx_busy_d = tx_busy;
    tx_done_d = 1'b0;
    if (tx_st != ST_IDLE && tick) begin
      tx_os_d = tx_end ? '0 : tx_os + 1'b1;
    end
    unique case (tx_st)
      ST_IDLE: begin
        // latch first, then align the start bit to a tick
        if (!tx_busy && bus.newd) begin
          tx_sh_d   = bus.dintx;
          tx_pb_d   = par_bit(bus.dintx);
          tx_busy_d = 1'b1;
        end else if (tx_busy && tick) begin
          tx_st_d = ST_START;
          tx_os_d = '0;
        end
      end
      ST_START: begin
        if (tx_end) begin
          tx_st_d  = ST_DATA;
          tx_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (tx_end) begin
          tx_sh_d = tx_sh >> 1;
          if (tx_cnt == BIT_LAST) begin
            tx_cnt_d = '0;
            tx_st_d  = HAS_PAR ? ST_PARITY : ST_STOP;
          end else begin
            tx_cnt_d = tx_cnt + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tx_end) begin
          tx_st_d  = ST_STOP;
          tx_cnt_d = '0;
        end
      end
      ST_STOP: begin
        if (tx_end) begin
          if (tx_cnt == STOP_LAST) begin
            tx_st_d   = ST_IDLE;
            tx_busy_d = 1'b0;
            tx_done_d = 1'b1;
          end else begin
            tx_cnt_d = tx_cnt + 1'b1;
          end
        end
      end
      default: tx_st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_line = 1'b1;
    unique case (1'b1)
      tx_st == ST_START:  tx_line = 1'b0;
      tx_st == ST_DATA:   tx_line = tx_sh[0];
      tx_st == ST_PARITY: tx_line = tx_pb;
      default:            tx_line = 1'b1;
    endcase
  end

  // ---------------- RX ----------------
  logic rx_in;

`ifdef UART_LOOPBACK_EN
  assign rx_in = loopback ? tx_line : bus.rx;
`else
  assign rx_in = bus.rx;
`endif

  logic [1:0] rx_sync;
  logic       rx_prev;
  logic       rx_s;
  logic       rx_fall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rx_in};
      rx_prev <= rx_s;
    end
  end

  assign rx_s    = rx_sync[1];
  assign rx_fall = rx_prev && !rx_s;

  uart_state_t          rx_st, rx_st_d;
  logic [OSW-1:0]       rx_os, rx_os_d;
  logic [3:0]           rx_cnt, rx_cnt_d;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_d;
  logic                 rx_pb, rx_pb_d;
  logic                 rx_fe, rx_fe_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_done, rx_done_d;
  logic                 rx_smp;
  logic                 rx_fe_now;

  // start bit is probed at half period, the rest a full period apart
  assign rx_smp = tick &&
    (rx_os == ((rx_st == ST_START) ? OS_MID : OS_LAST));
  assign rx_fe_now = rx_fe || !rx_s;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_st   <= ST_IDLE;
      rx_os   <= '0;
      rx_cnt  <= '0;
      rx_sh   <= '0;
      rx_pb   <= 1'b0;
      rx_fe   <= 1'b0;
      dout_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      rx_done <= 1'b0;
    end else begin
      rx_st   <= rx_st_d;
      rx_os   <= rx_os_d;
      rx_cnt  <= rx_cnt_d;
      rx_sh   <= rx_sh_d;
      rx_pb   <= rx_pb_d;
      rx_fe   <= rx_fe_d;
      dout_q  <= dout_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      rx_done <= rx_done_d;
    end
  end

  always_comb begin
    rx_st_d   = rx_st;
    rx_os_d   = rx_os;
    rx_cnt_d  = rx_cnt;
    rx_sh_d   = rx_sh;
    rx_pb_d   = rx_pb;
    rx_fe_d   = rx_fe;
    dout_d    = dout_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    rx_done_d = 1'b0;
    if (rx_st != ST_IDLE && tick) begin
      rx_os_d = rx_smp ? '0 : rx_os + 1'b1;
    end
    unique case (rx_st)
      ST_IDLE: begin
        if (rx_fall) begin
          rx_st_d = ST_START;
          rx_os_d = '0;
          rx_fe_d = 1'b0;
        end
      end
      ST_START: begin
        if (rx_smp) begin
          rx_st_d  = rx_s ? ST_IDLE : ST_DATA;
          rx_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (rx_smp) begin
          rx_sh_d = {rx_s, rx_sh[DATA_BITS-1:1]};
          if (rx_cnt == BIT_LAST) begin
            rx_cnt_d = '0;
            rx_st_d  = HAS_PAR ? ST_PARITY : ST_STOP;
          end else begin
            rx_cnt_d = rx_cnt + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (rx_smp) begin
          rx_pb_d  = rx_s;
          rx_st_d  = ST_STOP;
          rx_cnt_d = '0;
        end
      end
      ST_STOP: begin
        if (rx_smp) begin
          if (rx_cnt == STOP_LAST) begin
            rx_st_d   = ST_IDLE;
            rx_done_d = 1'b1;
            dout_d    = rx_sh;
            ferr_d    = rx_fe_now;
            perr_d    = HAS_PAR && (par_bit(rx_sh) != rx_pb);
          end else begin
            rx_fe_d  = rx_fe_now;
            rx_cnt_d = rx_cnt + 1'b1;
          end
        end
      end
      default: rx_st_d = ST_IDLE;
    endcase
  end

  assign bus.tx     = tx_line;
  assign bus.busytx = tx_busy;
  assign bus.donetx = tx_done;
  assign bus.doutrx = dout_q;
  assign bus.perr   = perr_q;
  assign bus.ferr   = ferr_q;
  assign bus.donerx = rx_done;

endmodule

// File: tb/tb_uart_cfg_core.sv
// tb_uart_cfg_core: directed scoreboard bench for default 8N1,
// even-parity and 7-bit/2-stop builds of uart_cfg_core.
module tb_uart_cfg_core;
  import uart_pkg::*;

  localparam int BIT  = 160;
  localparam int HALF = 80;

  typedef struct packed {
    logic [8:0] d;
    logic       p;
    logic       f;
  } rx_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;
  int hr, ht;

  rx_exp_t rxq[$];
  logic    txq[$];

  logic [2:0] rx_drv, newd_v;
  logic [8:0] din_v [3];
  logic [2:0] tx_w, dtx_w, drx_w, busy_w, perr_w, ferr_w;
  logic [8:0] dout_w [3];

`ifdef UART_LOOPBACK_EN
  logic lb;
`endif

  uart_cfg_core_if #(.DATA_BITS(8)) if_a ();
  uart_cfg_core_if #(.DATA_BITS(8)) if_b ();
  uart_cfg_core_if #(.DATA_BITS(7)) if_c ();

  assign if_a.rx    = rx_drv[0];
  assign if_b.rx    = rx_drv[1];
  assign if_c.rx    = rx_drv[2];
  assign if_a.newd  = newd_v[0];
  assign if_b.newd  = newd_v[1];
  assign if_c.newd  = newd_v[2];
  assign if_a.dintx = din_v[0][7:0];
  assign if_b.dintx = din_v[1][7:0];
  assign if_c.dintx = din_v[2][6:0];

  assign tx_w   = {if_c.tx, if_b.tx, if_a.tx};
  assign dtx_w  = {if_c.donetx, if_b.donetx, if_a.donetx};
  assign drx_w  = {if_c.donerx, if_b.donerx, if_a.donerx};
  assign busy_w = {if_c.busytx, if_b.busytx, if_a.busytx};
  assign perr_w = {if_c.perr, if_b.perr, if_a.perr};
  assign ferr_w = {if_c.ferr, if_b.ferr, if_a.ferr};
  assign dout_w[0] = {1'b0, if_a.doutrx};
  assign dout_w[1] = {1'b0, if_b.doutrx};
  assign dout_w[2] = {2'b00, if_c.doutrx};

  uart_cfg_core u_a (
    .clk      (clk),
    .rst      (rst),
`ifdef UART_LOOPBACK_EN
    .loopback (lb),
`endif
    .bus      (if_a.slave)
  );

  uart_cfg_core #(
    .PARITY (PAR_EVEN)
  ) u_b (
    .clk      (clk),
    .rst      (rst),
`ifdef UART_LOOPBACK_EN
    .loopback (1'b0),
`endif
    .bus      (if_b.slave)
  );

  uart_cfg_core #(
    .DATA_BITS (7),
    .STOP_BITS (2)
  ) u_c (
    .clk      (clk),
    .rst      (rst),
`ifdef UART_LOOPBACK_EN
    .loopback (1'b0),
`endif
    .bus      (if_c.slave)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_par(
    input logic [8:0] d,
    input int         nb,
    input int         pm
  );
    logic ones;
    ones = 1'b0;
    for (int i = 0; i < nb; i++) ones = ones ^ d[i];
    return (pm == PAR_ODD) ? ~ones : ones;
  endfunction

  task automatic rx_pop(input int k);
    rx_exp_t e;
    e = rxq.pop_front();
    chk("doutrx", 32'(dout_w[k]), 32'(e.d));
    chk("perr", 32'(perr_w[k]), 32'(e.p));
    chk("ferr", 32'(ferr_w[k]), 32'(e.f));
  endtask

  task automatic quiet(
    input  int k,
    input  int cyc,
    output int nrx,
    output int ntx
  );
    nrx = 0;
    ntx = 0;
    repeat (cyc) begin
      @(negedge clk);
      if (drx_w[k]) nrx++;
      if (dtx_w[k]) ntx++;
    end
  endtask

  // request a frame and return at the first negedge with the start bit
  task automatic start_tx(input int k, input logic [8:0] d);
    int n;
    din_v[k]  = d;
    newd_v[k] = 1'b1;
    n = 0;
    while (!busy_w[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("busy_rise", 32'(busy_w[k]), 32'd1);
    newd_v[k] = 1'b0;
    din_v[k]  = ~d;
    n = 0;
    while (tx_w[k] && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("start_edge", 32'(tx_w[k]), 32'd0);
  endtask

  task automatic tx_frame(
    input int         k,
    input logic [8:0] d,
    input int         nb,
    input int         pm,
    input int         ns
  );
    int nbit;
    int t_done;
    txq.delete();
    txq.push_back(1'b0);
    for (int i = 0; i < nb; i++) txq.push_back(d[i]);
    if (pm != PAR_NONE) txq.push_back(exp_par(d, nb, pm));
    for (int i = 0; i < ns; i++) txq.push_back(1'b1);
    nbit = txq.size();
    start_tx(k, d);
    t_done = 0;
    for (int c = 1; c <= nbit * BIT + 100; c++) begin
      @(negedge clk);
      if (c % BIT == HALF && txq.size() > 0) begin
        chk("tx_bit", 32'(tx_w[k]), 32'(txq.pop_front()));
        chk("busy_mid", 32'(busy_w[k]), 32'd1);
      end
      if (drx_w[k] && rxq.size() > 0) rx_pop(k);
      if (dtx_w[k]) begin
        t_done = c;
        break;
      end
    end
    chk("donetx_time", 32'(t_done), 32'(nbit * BIT));
    chk("tx_bits_left", 32'(txq.size()), 32'd0);
    @(negedge clk);
    chk("donetx_width", 32'(dtx_w[k]), 32'd0);
    chk("busy_fall", 32'(busy_w[k]), 32'd0);
  endtask

  task automatic rx_frame(
    input int         k,
    input logic [8:0] d,
    input int         nb,
    input int         pm,
    input logic       pbit,
    input int         ns,
    input logic [1:0] stopv
  );
    logic    bq[$];
    rx_exp_t e;
    int      nbit;
    logic    seen;
    bq.push_back(1'b0);
    for (int i = 0; i < nb; i++) bq.push_back(d[i]);
    if (pm != PAR_NONE) bq.push_back(pbit);
    for (int i = 0; i < ns; i++) bq.push_back(stopv[i]);
    nbit = bq.size();
    e.d = d;
    e.p = (pm != PAR_NONE) && (pbit != exp_par(d, nb, pm));
    e.f = 1'b0;
    for (int i = 0; i < ns; i++) if (!stopv[i]) e.f = 1'b1;
    rxq.push_back(e);
    seen = 1'b0;
    for (int c = 0; c < nbit * BIT + 200; c++) begin
      rx_drv[k] = (c / BIT < nbit) ? bq[c / BIT] : 1'b1;
      @(negedge clk);
      if (drx_w[k]) begin
        seen = 1'b1;
        rx_pop(k);
        break;
      end
    end
    chk("donerx_seen", 32'(seen), 32'd1);
    if (!seen) void'(rxq.pop_back());
    @(negedge clk);
    chk("donerx_width", 32'(drx_w[k]), 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rx_drv  = '1;
    newd_v  = '0;
    for (int i = 0; i < 3; i++) din_v[i] = '0;
`ifdef UART_LOOPBACK_EN
    lb = 1'b0;
`endif
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_tx", 32'(tx_w), 32'h7);
    chk("rst_busy", 32'(busy_w), 32'h0);
    chk("rst_donetx", 32'(dtx_w), 32'h0);
    chk("rst_donerx", 32'(drx_w), 32'h0);
    chk("rst_perr", 32'(perr_w), 32'h0);
    chk("rst_ferr", 32'(ferr_w), 32'h0);
    chk("rst_dout", 32'(dout_w[0]), 32'h0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    tx_frame(0, 9'h0A5, 8, PAR_NONE, 1);

    rx_frame(0, 9'h0C5, 8, PAR_NONE, 1'b0, 1, 2'b01);
    repeat (BIT) @(negedge clk);
    rx_frame(0, 9'h096, 8, PAR_NONE, 1'b0, 1, 2'b00);

    // line stuck low after a bad stop bit must not retrigger
    quiet(0, 3 * BIT, hr, ht);
    chk("break_no_rx", 32'(hr), 32'd0);
    rx_drv[0] = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    rx_drv[0] = 1'b0;
    repeat (5) @(negedge clk);
    rx_drv[0] = 1'b1;
    quiet(0, 3 * BIT, hr, ht);
    chk("glitch_no_rx", 32'(hr), 32'd0);
    chk("glitch_dout", 32'(dout_w[0]), 32'h96);
    chk("glitch_perr", 32'(perr_w[0]), 32'd0);
    chk("glitch_ferr", 32'(ferr_w[0]), 32'd1);

    tx_frame(1, 9'h007, 8, PAR_EVEN, 1);
    rx_frame(1, 9'h007, 8, PAR_EVEN, 1'b0, 1, 2'b01);
    repeat (BIT) @(negedge clk);
    rx_frame(1, 9'h0B4, 8, PAR_EVEN, 1'b0, 1, 2'b01);

    rx_frame(2, 9'h055, 7, PAR_NONE, 1'b0, 2, 2'b01);
    rx_drv[2] = 1'b1;
    repeat (BIT) @(negedge clk);
    tx_frame(2, 9'h02B, 7, PAR_NONE, 2);

    // abort a frame in its 4th data bit (value 0)
    start_tx(0, 9'h0C3);
    repeat (4 * BIT + HALF) @(negedge clk);
    chk("pre_rst_bit", 32'(tx_w[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_tx", 32'(tx_w[0]), 32'd1);
    chk("abort_busy", 32'(busy_w[0]), 32'd0);
    chk("abort_dout", 32'(dout_w[0]), 32'h0);
    chk("abort_ferr", 32'(ferr_w[0]), 32'd0);
    rst = 1'b1;
    quiet(0, 12 * BIT, hr, ht);
    chk("abort_no_donetx", 32'(ht), 32'd0);
    chk("abort_tx_idle", 32'(tx_w[0]), 32'd1);
    tx_frame(0, 9'h05A, 8, PAR_NONE, 1);

`ifdef UART_LOOPBACK_EN
    lb = 1'b1;
    repeat (4) @(negedge clk);
    rx_drv[0] = 1'b0;
    rxq.push_back('{d: 9'h03C, p: 1'b0, f: 1'b0});
    tx_frame(0, 9'h03C, 8, PAR_NONE, 1);
    chk("lb_rx_seen", 32'(rxq.size()), 32'd0);
    rxq.delete();
    rx_drv[0] = 1'b1;
    repeat (4) @(negedge clk);
    lb = 1'b0;
`endif

    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
